mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-outstanding memory port between instruction fetch (IFU) and load/store (LSU) in the riftCore pipeline. Grants one requester at a time, with LSU priority and a bounded starvation counter for IFU. Issues the latched request downstream and routes the response back to its owner. A front-end flush discards an in-flight IFU fetch without disturbing the memory-side handshake.

## Interface
- `AW`, 64: address width
- `DW`, 64: data width; strobe width is DW/8
- `STARVE_MAX`, 4: consecutive LSU grants, with IFU waiting, before IFU is forced to win; range 1..15

- `CLK` in 1: clock
- `RST` in 1: reset, synchronous, active-high
- `flush` in 1: front-end flush (feflush)
- `ifu_req_valid` in 1 / `ifu_req_addr` in AW: fetch request
- `ifu_req_ready` out 1: accept pulse for the fetch request
- `ifu_rsp_valid` out 1 / `ifu_rsp_data` out DW: fetch response
- `lsu_req_valid` in 1 / `lsu_req_addr` in AW / `lsu_req_wen` in 1 / `lsu_req_wdata` in DW / `lsu_req_wstrb` in DW/8: LSU request
- `lsu_req_ready` out 1: accept pulse for the LSU request
- `lsu_rsp_valid` out 1 / `lsu_rsp_data` out DW: LSU response; writes also respond
- `mem_req_valid` out 1 / `mem_req_ready` in 1: downstream request handshake
- `mem_req_addr` out AW / `mem_req_wen` out 1 / `mem_req_wdata` out DW / `mem_req_wstrb` out DW/8: downstream request payload
- `mem_rsp_valid` in 1 / `mem_rsp_data` in DW: downstream response
- `busy` out 1: state is not IDLE

## Operation
- FSM states are IDLE, ISSUE and WAIT. Registers: `owner` (0=IFU, 1=LSU), `drop`, `cnt` (4 bit), and the latched request fields.
- **IDLE**
  - Candidates are `lsu_req_valid` and `ifu_req_valid & ~flush`.
  - LSU wins unless both are candidates and `cnt == STARVE_MAX`, in which case IFU wins.
  - The winner's `*_req_ready` is asserted combinationally in the same cycle. This is the accept handshake.
  - On accept, latch addr/wen/wdata/wstrb (IFU forces wen=0, wstrb=0) and `owner`, clear `drop`, then go to ISSUE.
  - With no candidate, remain in IDLE.
- **cnt update on accept**
  - LSU granted while `ifu_req_valid & ~flush`: cnt+1, saturating at STARVE_MAX.
  - IFU granted: cnt=0.
  - Otherwise: unchanged.
- **ISSUE**
  - `mem_req_valid`=1 with the latched payload. It is held stable until `mem_req_ready`; valid is never withdrawn.
  - On `mem_req_ready`, go to WAIT.
- **WAIT**
  - On `mem_rsp_valid`, register the data and pulse the owner's `*_rsp_valid` next cycle, unless owner=IFU and `drop`=1. In that case no IFU pulse is produced.
  - Return to IDLE on the same edge.
- **flush**
  - Asserted in ISSUE or WAIT with owner=IFU (including the cycle `mem_rsp_valid` arrives): set `drop`.
  - No effect on an LSU-owned transaction.
  - Suppresses any IFU grant in IDLE that cycle.
- `mem_rsp_valid` outside WAIT is ignored.
- `*_rsp_data` holds its last value when `*_rsp_valid`=0.

## Timing
- **Reset**: state=IDLE, cnt=0, drop=0, owner=0. All outputs are 0, including `*_rsp_data` and the `mem_req_*` payload.
- **Reset mid-transaction**: return to IDLE immediately. A later stray `mem_rsp_valid` is ignored.
- **Cycle sequence**: accept at T; `mem_req_valid` from T+1; with ready at T+1, WAIT at T+2; `mem_rsp_valid` earliest T+2; owner rsp pulse at T+3; next accept possible at T+3.
- **Throughput**: minimum 3 cycles per transaction. Only one outstanding transaction at any time.
- `*_req_ready` is never asserted outside IDLE. Requesters hold valid until ready.
- `*_rsp_valid` is a single-cycle pulse. IFU and LSU pulses are never coincident.
- `busy`=1 in ISSUE and WAIT.

## Test plan
- **Single IFU fetch**: ifu valid, addr 0x80000000, at T; mem ready at T+1; rsp 0xDEADBEEF at T+2. Expect ifu_req_ready at T, mem_req_addr=0x80000000 and wen=0 at T+1, ifu_rsp_valid with 0xDEADBEEF at T+3, and no lsu_rsp_valid.
- **LSU write with backpressure**: lsu wen=1, wdata 0x1234, wstrb 0xFF; mem_req_ready held low 3 cycles. Expect payload stable for all 4 valid cycles and lsu_rsp_valid after the response.
- **Contention and starvation**: both valid continuously, STARVE_MAX=4. Expect grant order LSU,LSU,LSU,LSU,IFU,LSU…, with cnt returning to 0 after the IFU grant.
- **Flush drops a fetch**: IFU granted, flush pulsed in WAIT before the response. Expect no ifu_rsp_valid and an IDLE return after mem_rsp_valid; a following LSU request then completes normally.
- **Flush in IDLE and against LSU**: flush with only ifu valid gives no grant that cycle. Flush during an LSU transaction still produces lsu_rsp_valid.
- **Reset mid-WAIT**: RST=1 for one cycle in WAIT, then a stray mem_rsp_valid. Expect all outputs 0, no rsp pulses, busy=0, cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by instruction fetch and load/store.
// LSU has priority; a saturating starvation count forces an IFU grant.
module mem_port_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              ifu_req_valid,
  input  logic [AW-1:0]     ifu_req_addr,
  output logic              ifu_req_ready,
  output logic              ifu_rsp_valid,
  output logic [DW-1:0]     ifu_rsp_data,
  input  logic              lsu_req_valid,
  input  logic [AW-1:0]     lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DW-1:0]     lsu_req_wdata,
  input  logic [DW/8-1:0]   lsu_req_wstrb,
  output logic              lsu_req_ready,
  output logic              lsu_rsp_valid,
  output logic [DW-1:0]     lsu_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AW-1:0]     mem_req_addr,
  output logic              mem_req_wen,
  output logic [DW-1:0]     mem_req_wdata,
  output logic [DW/8-1:0]   mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [DW-1:0]     mem_rsp_data,
  output logic              busy
);

  localparam int         SW         = DW / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbState_e;

  arbState_e       state_r;
  arbState_e       nextState_s;
  logic            owner_r;
  logic            drop_r;
  logic [3:0]      cnt_r;
  logic [3:0]      cntNext_s;
  logic [AW-1:0]   addr_r;
  logic            wen_r;
  logic [DW-1:0]   wdata_r;
  logic [SW-1:0]   wstrb_r;
  logic            ifuRspValid_r;
  logic [DW-1:0]   ifuRspData_r;
  logic            lsuRspValid_r;
  logic [DW-1:0]   lsuRspData_r;
  logic            ifuCand_s;
  logic            lsuCand_s;
  logic            grantIfu_s;
  logic            grantLsu_s;
  logic            dropSet_s;
  logic            ifuRspFire_s;
  logic            lsuRspFire_s;

  // Candidates are masked by reset so no accept handshake escapes during it.
  assign ifuCand_s = ifu_req_valid & ~flush & ~RST;
  assign lsuCand_s = lsu_req_valid & ~RST;

  // Next-state and grant decode
  always_comb begin
    nextState_s = state_r;
    grantIfu_s  = 1'b0;
    grantLsu_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (lsuCand_s && !(ifuCand_s && (cnt_r == STARVE_LIM))) begin
          grantLsu_s  = 1'b1;
          nextState_s = ISSUE;
        end else if (ifuCand_s) begin
          grantIfu_s  = 1'b1;
          nextState_s = ISSUE;
        end else begin
          nextState_s = IDLE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          nextState_s = WAIT;
        end else begin
          nextState_s = ISSUE;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = WAIT;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Starvation count, flush-drop and response-fire decode
  always_comb begin
    cntNext_s = cnt_r;
    if (grantIfu_s) begin
      cntNext_s = 4'd0;
    end else if (grantLsu_s && ifuCand_s && (cnt_r != STARVE_LIM)) begin
      cntNext_s = cnt_r + 4'd1;
    end else begin
      cntNext_s = cnt_r;
    end
    dropSet_s    = (state_r != IDLE) & flush & ~owner_r;
    ifuRspFire_s = (state_r == WAIT) & mem_rsp_valid & ~owner_r & ~drop_r & ~flush;
    lsuRspFire_s = (state_r == WAIT) & mem_rsp_valid & owner_r;
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Latched request, ownership, starvation count and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_r       <= 1'b0;
      drop_r        <= 1'b0;
      cnt_r         <= 4'd0;
      addr_r        <= {AW{1'b0}};
      wen_r         <= 1'b0;
      wdata_r       <= {DW{1'b0}};
      wstrb_r       <= {SW{1'b0}};
      ifuRspValid_r <= 1'b0;
      ifuRspData_r  <= {DW{1'b0}};
      lsuRspValid_r <= 1'b0;
      lsuRspData_r  <= {DW{1'b0}};
    end else begin
      cnt_r         <= cntNext_s;
      ifuRspValid_r <= ifuRspFire_s;
      lsuRspValid_r <= lsuRspFire_s;
      if (grantLsu_s) begin
        owner_r <= 1'b1;
        drop_r  <= 1'b0;
        addr_r  <= lsu_req_addr;
        wen_r   <= lsu_req_wen;
        wdata_r <= lsu_req_wdata;
        wstrb_r <= lsu_req_wstrb;
      end else if (grantIfu_s) begin
        owner_r <= 1'b0;
        drop_r  <= 1'b0;
        addr_r  <= ifu_req_addr;
        wen_r   <= 1'b0;
        wdata_r <= {DW{1'b0}};
        wstrb_r <= {SW{1'b0}};
      end else if (dropSet_s) begin
        drop_r <= 1'b1;
      end
      // Data is only updated on a delivered pulse so each port holds its last response.
      if (ifuRspFire_s) begin
        ifuRspData_r <= mem_rsp_data;
      end
      if (lsuRspFire_s) begin
        lsuRspData_r <= mem_rsp_data;
      end
    end
  end

  assign ifu_req_ready = grantIfu_s;
  assign lsu_req_ready = grantLsu_s;
  assign ifu_rsp_valid = ifuRspValid_r;
  assign ifu_rsp_data  = ifuRspData_r;
  assign lsu_rsp_valid = lsuRspValid_r;
  assign lsu_rsp_data  = lsuRspData_r;
  assign mem_req_valid = (state_r == ISSUE);
  assign mem_req_addr  = addr_r;
  assign mem_req_wen   = wen_r;
  assign mem_req_wdata = wdata_r;
  assign mem_req_wstrb = wstrb_r;
  assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level reference model
// predicts grants, downstream payloads and routed responses.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic [63:0] ifu_req_addr = 64'd0;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [63:0] ifu_rsp_data;
  logic        lsu_req_valid = 1'b0;
  logic [63:0] lsu_req_addr = 64'd0;
  logic        lsu_req_wen = 1'b0;
  logic [63:0] lsu_req_wdata = 64'd0;
  logic [7:0]  lsu_req_wstrb = 8'd0;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;
  logic [63:0] lsu_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = 64'd0;
  logic        busy;

  mem_port_arbiter #(.AW(64), .DW(64), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    bit          isLsu;
  } reqT;

  typedef struct {
    bit          isLsu;
    logic [63:0] data;
    longint      due;
  } rspT;

  reqT    expReqQ[$];
  rspT    expRspQ[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  // Requester-side state and reference starvation count
  bit          ifuPend = 1'b0;
  bit          lsuPend = 1'b0;
  logic [63:0] ifuAddr = 64'd0;
  logic [63:0] lsuAddr = 64'd0;
  logic        lsuWen = 1'b0;
  logic [63:0] lsuWdata = 64'd0;
  logic [7:0]  lsuWstrb = 8'd0;
  int          starve = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: downstream payload and routed responses against the scoreboard
  always @(negedge CLK) begin
    rspT s;
    if (mem_req_valid === 1'b1) begin
      if (expReqQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL memReqUnexpected actual addr=%h required=no request", mem_req_addr);
      end else begin
        chk("memReqAddr", mem_req_addr, expReqQ[0].addr);
        chk("memReqWen", 64'(mem_req_wen), 64'(expReqQ[0].wen));
        chk("memReqWstrb", 64'(mem_req_wstrb), 64'(expReqQ[0].wstrb));
        if (expReqQ[0].isLsu) chk("memReqWdata", mem_req_wdata, expReqQ[0].wdata);
        if (mem_req_ready) void'(expReqQ.pop_front());
      end
    end
    if (ifu_rsp_valid === 1'b1 || lsu_rsp_valid === 1'b1) begin
      chk("rspCoincident", 64'(ifu_rsp_valid & lsu_rsp_valid), 64'd0);
      if (expRspQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL rspUnexpected actual ifu=%b lsu=%b required=no response", ifu_rsp_valid, lsu_rsp_valid);
      end else begin
        s = expRspQ.pop_front();
        chk("rspOwnerLsu", 64'(lsu_rsp_valid), 64'(s.isLsu));
        chk("rspData", s.isLsu ? lsu_rsp_data : ifu_rsp_data, s.data);
        chk("rspCycle", 64'(cyc), 64'(s.due));
      end
    end else if (expRspQ.size() > 0 && expRspQ[0].due <= cyc) begin
      checks++; errors++;
      $display("FAIL rspMissing actual=none required owner lsu=%0d data=%h", expRspQ[0].isLsu, expRspQ[0].data);
      void'(expRspQ.pop_front());
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic driveReqs();
    ifu_req_valid = ifuPend;
    ifu_req_addr  = ifuAddr;
    lsu_req_valid = lsuPend;
    lsu_req_addr  = lsuAddr;
    lsu_req_wen   = lsuWen;
    lsu_req_wdata = lsuWdata;
    lsu_req_wstrb = lsuWstrb;
  endtask

  task automatic newIfu();
    ifuPend = 1'b1;
    ifuAddr = {$urandom, $urandom};
  endtask

  task automatic newLsu();
    lsuPend  = 1'b1;
    lsuAddr  = {$urandom, $urandom};
    lsuWen   = 1'($urandom_range(0, 1));
    lsuWdata = {$urandom, $urandom};
    lsuWstrb = 8'($urandom);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_ifuReqReady"}, 64'(ifu_req_ready), 64'd0);
    chk({tag, "_lsuReqReady"}, 64'(lsu_req_ready), 64'd0);
    chk({tag, "_rspValids"}, 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    chk({tag, "_ifuRspData"}, ifu_rsp_data, 64'd0);
    chk({tag, "_lsuRspData"}, lsu_rsp_data, 64'd0);
    chk({tag, "_memReqValid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_memReqPayload"}, mem_req_addr | mem_req_wdata | 64'(mem_req_wstrb) | 64'(mem_req_wen), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // One arbitration attempt starting in IDLE; flushAt counts cycles after the accept.
  task automatic runTxn(input int readyDelay, input int rspDelay, input int flushAt,
                        input logic [63:0] rdata, input bit flushIdle, input bit rstInWait,
                        output int obs);
    bit  ifuC, lsuC, lsuWin, drop;
    int  idx;
    reqT r;
    rspT s;
    driveReqs();
    flush         = flushIdle;
    mem_req_ready = 1'b0;
    mem_rsp_valid = ($urandom_range(0, 3) == 0);
    mem_rsp_data  = {$urandom, $urandom};
    ifuC   = ifuPend && !flushIdle;
    lsuC   = lsuPend;
    lsuWin = lsuC && !(ifuC && starve == STARVE_MAX);
    @(negedge CLK);
    obs = ifu_req_ready ? 1 : (lsu_req_ready ? 2 : 0);
    chk("ifuReqReady", 64'(ifu_req_ready), 64'(ifuC && !lsuWin));
    chk("lsuReqReady", 64'(lsu_req_ready), 64'(lsuWin));
    chk("busyIdle", 64'(busy), 64'd0);
    if (!ifuC && !lsuC) begin
      step();
      flush = 1'b0;
      mem_rsp_valid = 1'b0;
      return;
    end
    if (lsuWin) begin
      r = '{addr: lsuAddr, wen: lsuWen, wdata: lsuWdata, wstrb: lsuWstrb, isLsu: 1'b1};
      if (ifuC && starve < STARVE_MAX) starve++;
      lsuPend = 1'b0;
    end else begin
      r = '{addr: ifuAddr, wen: 1'b0, wdata: 64'd0, wstrb: 8'd0, isLsu: 1'b0};
      starve = 0;
      ifuPend = 1'b0;
    end
    expReqQ.push_back(r);
    step();
    drop = 1'b0;
    idx  = 1;
    for (int i = 0; i <= readyDelay; i++) begin
      driveReqs();
      flush         = (idx == flushAt);
      mem_req_ready = (i == readyDelay);
      mem_rsp_valid = ($urandom_range(0, 2) == 0);
      mem_rsp_data  = {$urandom, $urandom};
      if (flush && !lsuWin) drop = 1'b1;
      @(negedge CLK);
      chk("issueMemReqValid", 64'(mem_req_valid), 64'd1);
      chk("issueBusy", 64'(busy), 64'd1);
      chk("issueNoReady", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      step();
      idx++;
    end
    for (int j = 0; j <= rspDelay; j++) begin
      driveReqs();
      flush         = (idx == flushAt);
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = (j == rspDelay) && !rstInWait;
      mem_rsp_data  = (j == rspDelay) ? rdata : {$urandom, $urandom};
      RST           = rstInWait;
      if (flush && !lsuWin) drop = 1'b1;
      if (j == rspDelay && !rstInWait && (lsuWin || !drop)) begin
        s = '{isLsu: lsuWin, data: rdata, due: cyc + 1};
        expRspQ.push_back(s);
      end
      @(negedge CLK);
      chk("waitMemReqValid", 64'(mem_req_valid), 64'd0);
      chk("waitBusy", 64'(busy), 64'd1);
      chk("waitNoReady", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      step();
      idx++;
      if (rstInWait) begin
        RST     = 1'b0;
        starve  = 0;
        ifuPend = 1'b0;
        lsuPend = 1'b0;
        driveReqs();
        flush = 1'b0;
        mem_rsp_valid = 1'b0;
        return;
      end
    end
    flush         = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
  endtask

  // Both requesters continuously valid from a zero starvation count
  task automatic contention(input int n);
    int obs;
    for (int k = 0; k < n; k++) begin
      if (!ifuPend) newIfu();
      if (!lsuPend) newLsu();
      runTxn($urandom_range(0, 1), $urandom_range(0, 1), -1, {$urandom, $urandom}, 1'b0, 1'b0, obs);
      chk("grantOrder", 64'(obs), (k % (STARVE_MAX + 1) == STARVE_MAX) ? 64'd1 : 64'd2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int obs;
    // Reset with requests and a stray response present
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    mem_rsp_valid = 1'b1;
    @(negedge CLK);
    checkAllZero("reset");
    step();
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    checkAllZero("postReset");
    step();

    // Single IFU fetch
    ifuPend = 1'b1;
    ifuAddr = 64'h0000_0000_8000_0000;
    runTxn(0, 0, -1, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, obs);
    chk("singleFetchGrant", 64'(obs), 64'd1);

    // LSU write with three cycles of backpressure
    lsuPend = 1'b1; lsuAddr = 64'h0000_0000_0000_1000; lsuWen = 1'b1;
    lsuWdata = 64'h1234; lsuWstrb = 8'hFF;
    runTxn(3, 1, -1, 64'h0000_0000_0000_0000, 1'b0, 1'b0, obs);
    chk("lsuWriteGrant", 64'(obs), 64'd2);

    contention(12);

    // Flush in WAIT drops the fetch; a following LSU request completes
    ifuPend = 1'b0; lsuPend = 1'b0;
    newIfu();
    runTxn(0, 2, 3, 64'h0000_0000_0BAD_F00D, 1'b0, 1'b0, obs);
    chk("flushWaitGrant", 64'(obs), 64'd1);
    newLsu();
    runTxn(1, 0, -1, 64'h0000_0000_CAFE_0001, 1'b0, 1'b0, obs);
    chk("afterFlushLsuGrant", 64'(obs), 64'd2);
    // Flush on the response cycle
    newIfu();
    runTxn(0, 0, 2, 64'h0000_0000_5555_AAAA, 1'b0, 1'b0, obs);
    // Flush in IDLE suppresses the only candidate, then it is granted
    newIfu();
    runTxn(0, 0, -1, 64'h0000_0000_0000_0001, 1'b1, 1'b0, obs);
    chk("flushIdleNoGrant", 64'(obs), 64'd0);
    runTxn(0, 0, -1, 64'h0000_0000_0000_0002, 1'b0, 1'b0, obs);
    chk("flushIdleLaterGrant", 64'(obs), 64'd1);
    // Flush during an LSU transaction is ignored
    newLsu();
    runTxn(1, 1, 2, 64'h0000_0000_7777_7777, 1'b0, 1'b0, obs);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      if (!ifuPend && $urandom_range(0, 2) != 0) newIfu();
      if (!lsuPend && $urandom_range(0, 1) != 0) newLsu();
      runTxn($urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1,
             {$urandom, $urandom}, ($urandom_range(0, 5) == 0), 1'b0, obs);
    end

    // Build a nonzero starvation count, then reset in the middle of WAIT
    ifuPend = 1'b0; lsuPend = 1'b0;
    newIfu();
    runTxn(0, 0, -1, 64'h0000_0000_0000_00A1, 1'b0, 1'b0, obs);
    newIfu(); newLsu();
    runTxn(0, 0, -1, 64'h0000_0000_0000_00A2, 1'b0, 1'b0, obs);
    chk("preResetLsuGrant", 64'(obs), 64'd2);
    newLsu();
    runTxn(0, 2, -1, 64'h0000_0000_0000_00A3, 1'b0, 1'b1, obs);
    @(negedge CLK);
    checkAllZero("midWaitReset");
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h0000_0000_0000_0BAD;
    @(negedge CLK);
    chk("strayRspBusy", 64'(busy), 64'd0);
    step();
    mem_rsp_valid = 1'b0;
    @(negedge CLK);
    chk("strayRspNoPulse", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    step();

    // Starvation count restarts from zero after the reset
    contention(10);

    ifuPend = 1'b0; lsuPend = 1'b0;
    driveReqs();
    repeat (3) step();
    chk("reqQueueDrained", 64'(expReqQ.size()), 64'd0);
    chk("rspQueueDrained", 64'(expRspQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
